ddr3_pg_arb: RTL

Round-robin arbiter that shares the single DDR3 page-transfer engine among up to N_REQ page requesters: hit buffer controllers writing pages and host readout reading pages. Each requester uses the same four-phase req/optype/addr/ack handshake the hit buffer controller already speaks. The arbiter forwards one request at a time to the engine, returns the completion to the winning requester, and drives a grant index so the top level can mux the per-requester page DPRAM ports. It lives in the DDR3 UI clock domain, between the requesters and the DDR3 transfer engine.

---
 rtl/ddr3_pg_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ddr3_pg_arb.sv
// Round-robin arbiter that shares one DDR3 page-transfer engine among N_REQ
// requesters using a four-phase req/ack handshake, with a hi-priority class and an ack watchdog.
module ddr3_pg_arb #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N_REQ-1:0]      hi_prio,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      optype,
    input  logic [28*N_REQ-1:0]   addr,
    output logic [N_REQ-1:0]      ack,
    output logic                  xfer_req,
    output logic                  xfer_optype,
    output logic [27:0]           xfer_addr,
    input  logic                  xfer_ack,
    output logic [IDX_W-1:0]      gnt_idx,
    output logic                  busy,
    output logic [15:0]           n_xfers,
    output logic                  timeout_err,
    input  logic                  err_clr
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_REL, S_ACK} state_t;

    localparam logic [15:0] WD_LIM = 16'(TIMEOUT);

    state_t           state, state_next;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] win;
    logic             win_vld;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] pool;
    logic [27:0]      win_addr;
    logic             win_op;
    logic [15:0]      wd_cnt;
    logic             wd_run;
    logic             wd_hit;

    // The high-priority class preempts only the candidate pool; both classes share one rotation pointer.
    always_comb begin
        elig    = en ? req : '0;
        pool    = (|(elig & hi_prio)) ? (elig & hi_prio) : elig;
        win     = last;
        win_vld = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_vld && pool[(int'(last) + k) % N_REQ]) begin
                win     = IDX_W'((int'(last) + k) % N_REQ);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_op   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                win_addr = addr[28*i +: 28];
                win_op   = optype[i];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (win_vld)       state_next = S_XFER;
            S_XFER: if (xfer_ack)      state_next = S_REL;
            S_REL:  if (!xfer_ack)     state_next = S_ACK;
            S_ACK:  if (!req[gnt_idx]) state_next = S_IDLE;
            default:                   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Watchdog saturates at its limit so the sticky error is raised exactly once per stall.
    assign wd_run = (state == S_XFER) || (state == S_REL);
    assign wd_hit = wd_run && (wd_cnt == WD_LIM - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!wd_run)              wd_cnt <= '0;
            else if (wd_cnt < WD_LIM) wd_cnt <= wd_cnt + 16'd1;
            if (wd_hit)               timeout_err <= 1'b1;
            else if (err_clr)         timeout_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack         <= '0;
            xfer_req    <= 1'b0;
            xfer_optype <= 1'b0;
            xfer_addr   <= '0;
            gnt_idx     <= '0;
            last        <= IDX_W'(N_REQ - 1);
            busy        <= 1'b0;
            n_xfers     <= '0;
        end else begin
            busy <= (state_next != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        gnt_idx     <= win;
                        xfer_optype <= win_op;
                        xfer_addr   <= win_addr;
                        xfer_req    <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (xfer_ack) xfer_req <= 1'b0;
                end
                S_REL: begin
                    if (!xfer_ack) ack <= N_REQ'(1) << gnt_idx;
                end
                S_ACK: begin
                    if (!req[gnt_idx]) begin
                        ack     <= '0;
                        last    <= gnt_idx;
                        n_xfers <= n_xfers + 16'd1;
                    end
                end
                default: begin
                    ack      <= '0;
                    xfer_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
